// File: rtl/riscv_core_pkg.sv
// Shared definitions for the core's load/store path: access-size encodings,
// LSU sequencer states and small byte-lane helpers.
package riscv_core_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ0,
        ST_WAIT0,
        ST_REQ1,
        ST_WAIT1,
        ST_RESP
    } lsu_state_e;

    function automatic logic [2:0] size_nbytes(input logic [1:0] sz);
        case (sz)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            SZ_WORD: return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    // Byte enables across two consecutive words; low nibble = first word.
    function automatic logic [7:0] be_mask(input logic [1:0] sz, input logic [1:0] off);
        logic [7:0] m;
        case (sz)
            SZ_BYTE: m = 8'h01;
            SZ_HALF: m = 8'h03;
            SZ_WORD: m = 8'h0F;
            default: m = 8'h00;
        endcase
        return m << off;
    endfunction

endpackage

// File: rtl/riscv_core_ldextend.sv
// Load-data extension: sign- or zero-extends a right-justified byte/half,
// passes words through unchanged.
module riscv_core_ldextend
    import riscv_core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      i_size,
    input  logic            i_su_extend,
    input  logic [XLEN-1:0] i_raw,
    output logic [XLEN-1:0] o_data
);

    logic w_sb;
    logic w_sh;

    assign w_sb = !i_su_extend && i_raw[7];
    assign w_sh = !i_su_extend && i_raw[15];

    always_comb begin
        o_data = i_raw;
        case (i_size)
            SZ_BYTE: o_data = {{(XLEN-8){w_sb}}, i_raw[7:0]};
            SZ_HALF: o_data = {{(XLEN-16){w_sh}}, i_raw[15:0]};
            default: o_data = i_raw;
        endcase
    end

endmodule

// File: rtl/riscv_core_lsu_ctrl.sv
// LSU sequencer: one access at a time onto a req/gnt + rvalid data bus,
// splitting word-crossing accesses into two aligned transactions.
module riscv_core_lsu_ctrl
    import riscv_core_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter bit ALLOW_MISALIGN = 1'b1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_lsu_req_valid,
    output logic            o_lsu_req_ready,
    input  logic            i_lsu_we,
    input  logic [XLEN-1:0] i_lsu_addr,
    input  logic [1:0]      i_lsu_size,
    input  logic            i_lsu_su_extend,
    input  logic [XLEN-1:0] i_lsu_wdata,
    output logic            o_lsu_rsp_valid,
    output logic [XLEN-1:0] o_lsu_rdata,
    output logic            o_lsu_fault,
    output logic            o_lsu_busy,
    output logic            o_dmem_req,
    input  logic            i_dmem_gnt,
    output logic            o_dmem_we,
    output logic [XLEN-1:0] o_dmem_addr,
    output logic [3:0]      o_dmem_be,
    output logic [XLEN-1:0] o_dmem_wdata,
    input  logic            i_dmem_rvalid,
    input  logic [XLEN-1:0] i_dmem_rdata
);

    lsu_state_e      r_state, w_next;
    logic            r_we, r_su, r_split, r_fault;
    logic [XLEN-1:0] r_addr, r_wdata, r_lo, r_hi;
    logic [1:0]      r_size;

    logic              w_accept, w_in_split, w_in_fault;
    logic              w_req, w_second;
    logic [XLEN-1:0]   w_word0, w_ext, w_raw;
    logic [7:0]        w_m8;
    logic [2*XLEN-1:0] w_w64, w_raw64;
    logic [5:0]        w_shamt;

    assign w_accept   = (r_state == ST_IDLE) && i_lsu_req_valid;
    assign w_in_split = ({1'b0, i_lsu_addr[1:0]} + size_nbytes(i_lsu_size)) > 3'd4;
    assign w_in_fault = (i_lsu_size == SZ_ILL) || (w_in_split && !ALLOW_MISALIGN);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (i_lsu_req_valid) w_next = w_in_fault ? ST_RESP : ST_REQ0;
            ST_REQ0:  if (i_dmem_gnt)      w_next = ST_WAIT0;
            ST_WAIT0: if (i_dmem_rvalid)   w_next = r_split ? ST_REQ1 : ST_RESP;
            ST_REQ1:  if (i_dmem_gnt)      w_next = ST_WAIT1;
            ST_WAIT1: if (i_dmem_rvalid)   w_next = ST_RESP;
            ST_RESP:                       w_next = ST_IDLE;
            default:                       w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_we    <= 1'b0;
            r_su    <= 1'b0;
            r_split <= 1'b0;
            r_fault <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_size  <= SZ_BYTE;
            r_lo    <= '0;
            r_hi    <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_we    <= i_lsu_we;
                r_su    <= i_lsu_su_extend;
                r_split <= w_in_split;
                r_fault <= w_in_fault;
                r_addr  <= i_lsu_addr;
                r_wdata <= i_lsu_wdata;
                r_size  <= i_lsu_size;
                r_hi    <= '0;
            end
            if (r_state == ST_WAIT0 && i_dmem_rvalid) r_lo <= i_dmem_rdata;
            if (r_state == ST_WAIT1 && i_dmem_rvalid) r_hi <= i_dmem_rdata;
        end
    end

    // Bus outputs are pure functions of registered state, so they hold
    // steady for the whole grant wait and read zero outside REQx.
    assign w_req    = (r_state == ST_REQ0) || (r_state == ST_REQ1);
    assign w_second = (r_state == ST_REQ1);
    assign w_word0  = {r_addr[XLEN-1:2], 2'b00};
    assign w_m8     = be_mask(r_size, r_addr[1:0]);
    assign w_shamt  = {1'b0, r_addr[1:0], 3'b000};
    assign w_w64    = {{XLEN{1'b0}}, r_wdata} << w_shamt;
    assign w_raw64  = {r_hi, r_lo} >> w_shamt;
    assign w_raw    = w_raw64[XLEN-1:0];

    assign o_dmem_req   = w_req;
    assign o_dmem_we    = w_req && r_we;
    assign o_dmem_addr  = !w_req ? '0 : (w_second ? w_word0 + XLEN'(4) : w_word0);
    assign o_dmem_be    = !w_req ? 4'b0 : (w_second ? w_m8[7:4] : w_m8[3:0]);
    assign o_dmem_wdata = !w_req ? '0 : (w_second ? w_w64[2*XLEN-1:XLEN] : w_w64[XLEN-1:0]);

    riscv_core_ldextend #(.XLEN(XLEN)) u_ldext (
        .i_size      (r_size),
        .i_su_extend (r_su),
        .i_raw       (w_raw),
        .o_data      (w_ext)
    );

    assign o_lsu_req_ready = (r_state == ST_IDLE);
    assign o_lsu_busy      = !o_lsu_req_ready;
    assign o_lsu_rsp_valid = (r_state == ST_RESP);
    assign o_lsu_fault     = (r_state == ST_RESP) && r_fault;
    assign o_lsu_rdata     = (r_state == ST_RESP && !r_fault && !r_we) ? w_ext : '0;

endmodule

// File: tb/tb_riscv_core_lsu_ctrl.sv
// Directed + randomized bench for the LSU sequencer against a byte-addressed
// memory model; a second instance covers the no-misalign fault path.
module tb_riscv_core_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid, valid_nm, we, su, gnt, rvalid;
    logic [31:0] addr, wdata, rdata;
    logic [1:0]  size;

    logic        ready, rsp_valid, fault, busy, dreq, dwe;
    logic [31:0] lrdata, daddr, dwdata;
    logic [3:0]  dbe;

    logic        ready_n, rsp_valid_n, fault_n, busy_n, dreq_n, dwe_n;
    logic [31:0] lrdata_n, daddr_n, dwdata_n;
    logic [3:0]  dbe_n;

    int          checks = 0;
    int          errors = 0;
    logic        nm_req_seen = 1'b0;
    logic [31:0] got_rdata;
    logic [7:0]  mem [logic [31:0]];

    always #5 clk = ~clk;

    riscv_core_lsu_ctrl #(.XLEN(32), .ALLOW_MISALIGN(1'b1)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_lsu_req_valid(valid), .o_lsu_req_ready(ready),
        .i_lsu_we(we), .i_lsu_addr(addr), .i_lsu_size(size), .i_lsu_su_extend(su),
        .i_lsu_wdata(wdata), .o_lsu_rsp_valid(rsp_valid), .o_lsu_rdata(lrdata),
        .o_lsu_fault(fault), .o_lsu_busy(busy), .o_dmem_req(dreq), .i_dmem_gnt(gnt),
        .o_dmem_we(dwe), .o_dmem_addr(daddr), .o_dmem_be(dbe), .o_dmem_wdata(dwdata),
        .i_dmem_rvalid(rvalid), .i_dmem_rdata(rdata)
    );

    riscv_core_lsu_ctrl #(.XLEN(32), .ALLOW_MISALIGN(1'b0)) u_dut_nm (
        .i_clk(clk), .i_rst_n(rst_n), .i_lsu_req_valid(valid_nm), .o_lsu_req_ready(ready_n),
        .i_lsu_we(we), .i_lsu_addr(addr), .i_lsu_size(size), .i_lsu_su_extend(su),
        .i_lsu_wdata(wdata), .o_lsu_rsp_valid(rsp_valid_n), .o_lsu_rdata(lrdata_n),
        .o_lsu_fault(fault_n), .o_lsu_busy(busy_n), .o_dmem_req(dreq_n), .i_dmem_gnt(gnt),
        .o_dmem_we(dwe_n), .o_dmem_addr(daddr_n), .o_dmem_be(dbe_n), .o_dmem_wdata(dwdata_n),
        .i_dmem_rvalid(rvalid), .i_dmem_rdata(rdata)
    );

    always @(posedge clk) if (dreq_n) nm_req_seen <= 1'b1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] rd_byte(input logic [31:0] a);
        if (!mem.exists(a)) mem[a] = 8'($urandom);
        return mem[a];
    endfunction

    task automatic put_word(input logic [31:0] a, input logic [31:0] d);
        for (int i = 0; i < 4; i++) mem[a + i] = d[8*i +: 8];
    endtask

    // Drives one access through the main DUT and plays the bus slave.
    task automatic do_access(input logic we_i, input logic [31:0] a, input logic [1:0] sz,
                             input logic su_i, input logic [31:0] wd,
                             input int gd, input int rd);
        int          nb, nw;
        logic [31:0] words [2];
        logic [3:0]  bes [2];
        logic [31:0] wds [2];
        logic [31:0] ba, wa, exp_rd, lm, bw;
        nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
        nw = 0;
        exp_rd = 32'h0;
        for (int i = 0; i < nb; i++) begin
            ba = a + 32'(i);
            wa = {ba[31:2], 2'b00};
            if (nw == 0 || wa != words[nw-1]) begin
                words[nw] = wa; bes[nw] = 4'h0; wds[nw] = 32'h0; nw++;
            end
            bes[nw-1][ba[1:0]] = 1'b1;
            wds[nw-1][8*ba[1:0] +: 8] = wd[8*i +: 8];
            exp_rd = exp_rd | (32'(rd_byte(ba)) << (8*i));
        end
        if (!su_i && sz == 2'd0 && exp_rd[7])  exp_rd = exp_rd | 32'hFFFF_FF00;
        if (!su_i && sz == 2'd1 && exp_rd[15]) exp_rd = exp_rd | 32'hFFFF_0000;
        if (we_i) exp_rd = 32'h0;

        valid = 1'b1; we = we_i; addr = a; size = sz; su = su_i; wdata = wd;
        tick();
        valid = 1'b0; addr = $urandom; wdata = $urandom; size = 2'($urandom); su = 1'($urandom);
        chk("ready_low_after_accept", {31'b0, ready}, 32'd0);
        chk("busy_after_accept", {31'b0, busy}, 32'd1);
        if (sz == 2'd3) begin
            chk("ill_rsp_valid", {31'b0, rsp_valid}, 32'd1);
            chk("ill_fault", {31'b0, fault}, 32'd1);
            chk("ill_rdata", lrdata, 32'd0);
            chk("ill_no_req", {31'b0, dreq}, 32'd0);
            tick();
            chk("ill_ready_back", {31'b0, ready}, 32'd1);
            return;
        end
        for (int t = 0; t < nw; t++) begin
            lm = 32'h0;
            for (int j = 0; j < 4; j++) if (bes[t][j]) lm[8*j +: 8] = 8'hFF;
            for (int d = 0; d <= gd; d++) begin
                chk("bus_req", {31'b0, dreq}, 32'd1);
                chk("bus_addr", daddr, words[t]);
                chk("bus_be", {28'b0, dbe}, {28'b0, bes[t]});
                chk("bus_we", {31'b0, dwe}, {31'b0, we_i});
                if (we_i) chk("bus_wdata", dwdata & lm, wds[t]);
                rvalid = 1'($urandom);
                rdata = $urandom;
                gnt = (d == gd);
                tick();
                gnt = 1'b0; rvalid = 1'b0;
            end
            chk("wait_req_low", {31'b0, dreq}, 32'd0);
            for (int d = 0; d < rd; d++) begin
                gnt = 1'($urandom);
                tick();
                gnt = 1'b0;
                chk("wait_no_rsp", {31'b0, rsp_valid}, 32'd0);
            end
            for (int j = 0; j < 4; j++) bw[8*j +: 8] = rd_byte(words[t] + 32'(j));
            rdata = bw; rvalid = 1'b1;
            tick();
            rvalid = 1'b0; rdata = $urandom;
        end
        chk("rsp_valid", {31'b0, rsp_valid}, 32'd1);
        chk("rsp_fault", {31'b0, fault}, 32'd0);
        chk("rsp_rdata", lrdata, exp_rd);
        chk("rsp_not_ready", {31'b0, ready}, 32'd0);
        got_rdata = lrdata;
        tick();
        chk("rsp_one_cycle", {31'b0, rsp_valid}, 32'd0);
        chk("ready_after_rsp", {31'b0, ready}, 32'd1);
        if (we_i) for (int i = 0; i < nb; i++) mem[a + 32'(i)] = wd[8*i +: 8];
    endtask

    task automatic fault_nm(input logic [31:0] a, input logic [1:0] sz);
        valid_nm = 1'b1; we = 1'b0; addr = a; size = sz; su = 1'b0;
        tick();
        valid_nm = 1'b0;
        chk("nm_rsp_valid", {31'b0, rsp_valid_n}, 32'd1);
        chk("nm_fault", {31'b0, fault_n}, 32'd1);
        chk("nm_rdata", lrdata_n, 32'd0);
        chk("nm_no_req", {31'b0, dreq_n}, 32'd0);
        tick();
        chk("nm_rsp_done", {31'b0, rsp_valid_n}, 32'd0);
        chk("nm_ready", {31'b0, ready_n}, 32'd1);
    endtask

    initial begin
        logic [31:0] ra;
        logic [1:0]  rs;
        rst_n = 1'b0; valid = 1'b0; valid_nm = 1'b0; we = 1'b0; su = 1'b0;
        gnt = 1'b0; rvalid = 1'b0; addr = 32'h0; wdata = 32'h0; rdata = 32'h0; size = 2'd0;
        tick(); tick();
        chk("rst_ready", {31'b0, ready}, 32'd1);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_fault", {31'b0, fault}, 32'd0);
        chk("rst_req", {31'b0, dreq}, 32'd0);
        chk("rst_we", {31'b0, dwe}, 32'd0);
        chk("rst_be", {28'b0, dbe}, 32'd0);
        chk("rst_addr", daddr, 32'd0);
        chk("rst_wdata", dwdata, 32'd0);
        chk("rst_rdata", lrdata, 32'd0);
        rst_n = 1'b1;
        tick();

        put_word(32'h100, 32'hDEADBEEF);
        do_access(1'b0, 32'h100, 2'd2, 1'b0, 32'h0, 0, 0);
        chk("lw_aligned_value", got_rdata, 32'hDEADBEEF);

        put_word(32'h200, 32'h80AB_CDEF);
        do_access(1'b0, 32'h203, 2'd0, 1'b0, 32'h0, 0, 0);
        chk("lb_sext_value", got_rdata, 32'hFFFF_FF80);
        do_access(1'b0, 32'h203, 2'd0, 1'b1, 32'h0, 0, 0);
        chk("lbu_zext_value", got_rdata, 32'h0000_0080);

        put_word(32'h100, 32'h33221100);
        put_word(32'h104, 32'h77665544);
        do_access(1'b0, 32'h102, 2'd2, 1'b0, 32'h0, 0, 0);
        chk("lw_split_value", got_rdata, 32'h55443322);

        do_access(1'b1, 32'hFFFF_FFFF, 2'd1, 1'b0, 32'h0000_ABCD, 0, 0);
        do_access(1'b0, 32'hFFFF_FFFF, 2'd1, 1'b1, 32'h0, 1, 1);
        chk("lhu_wrap_readback", got_rdata, 32'h0000_ABCD);

        do_access(1'b0, 32'h400, 2'd3, 1'b0, 32'h0, 0, 0);
        fault_nm(32'h101, 2'd2);
        fault_nm(32'h203, 2'd1);
        fault_nm(32'h200, 2'd3);

        // Grant held off with stray rvalid, then reset lands in WAIT0.
        put_word(32'h300, 32'h12345678);
        valid = 1'b1; we = 1'b0; addr = 32'h300; size = 2'd2; su = 1'b0;
        tick();
        valid = 1'b0;
        for (int d = 0; d < 3; d++) begin
            chk("hold_addr", daddr, 32'h300);
            chk("hold_be", {28'b0, dbe}, 32'hF);
            chk("hold_req", {31'b0, dreq}, 32'd1);
            rvalid = 1'b1;
            tick();
            rvalid = 1'b0;
        end
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
        chk("wait0_req_low", {31'b0, dreq}, 32'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_ready", {31'b0, ready}, 32'd1);
        chk("midrst_rsp", {31'b0, rsp_valid}, 32'd0);
        chk("midrst_addr", daddr, 32'd0);
        chk("midrst_be", {28'b0, dbe}, 32'd0);
        rvalid = 1'b1; rdata = 32'hCAFEF00D;
        tick();
        rvalid = 1'b0;
        chk("stale_rvalid_rsp", {31'b0, rsp_valid}, 32'd0);
        chk("stale_rvalid_ready", {31'b0, ready}, 32'd1);
        do_access(1'b0, 32'h300, 2'd2, 1'b0, 32'h0, 0, 0);

        for (int n = 0; n < 200; n++) begin
            ra = ($urandom_range(0, 3) == 0) ? $urandom : 32'h400 + 32'($urandom_range(0, 63));
            rs = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            do_access(1'($urandom), ra, rs, 1'($urandom), $urandom,
                      $urandom_range(0, 3), $urandom_range(0, 3));
        end
        for (int n = 0; n < 20; n++) begin
            ra = 32'h500 + 32'($urandom_range(1, 3));
            fault_nm(ra, 2'd2);
        end

        chk("nm_never_req", {31'b0, nm_req_seen}, 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
